// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit feeding the register-file write port.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier runs out of set bits.
module muldiv_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SEL_W-1:0] i_dest_sel,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_wb_data,
    output logic [SEL_W-1:0] o_wb_sel,
    output logic             o_wb_wrt
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;

    typedef enum logic [1:0] {StIdle, StCalc, StWb} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_wb_data, w_wb_data_nxt;
    logic [SEL_W-1:0]   r_wb_sel, w_wb_sel_nxt;

    logic               w_is_div;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_mul_final;
    logic [WIDTH-1:0]   w_b_shr;
    logic [WIDTH:0]     w_div_shl;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_acc;
    logic               w_last;
    logic [WIDTH-1:0]   w_result;

    assign w_is_div = r_op[1];

    // Shift-add step: add multiplicand into the upper half, then shift right keeping the carry.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_b[0]) begin
            w_mul_sum = w_mul_sum + {1'b0, r_a};
        end
        w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    assign w_b_shr = {1'b0, r_b[WIDTH-1:1]};

    // Restoring step: acc holds {remainder, dividend/quotient}; compare on WIDTH+1 bits.
    assign w_div_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_shl >= {1'b0, r_b});
    assign w_div_diff = w_div_shl[WIDTH-1:0] - r_b;
    assign w_div_acc  = {(w_div_ge ? w_div_diff : w_div_shl[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0] w_align_sh;

    // Skipped iterations would only shift right, so apply them all at once.
    assign w_align_sh  = CW'(WIDTH - 1) - r_cnt;
    assign w_mul_final = w_mul_acc >> w_align_sh;
    assign w_last      = (r_cnt == CW'(WIDTH - 1)) || (!w_is_div && (w_b_shr == '0));
`else
    assign w_mul_final = w_mul_acc;
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        unique case (r_op)
            OP_MUL:  w_result = w_mul_final[WIDTH-1:0];
            OP_MULH: w_result = w_mul_final[2*WIDTH-1:WIDTH];
            OP_DIVU: w_result = w_div_acc[WIDTH-1:0];
            default: w_result = w_div_acc[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_sel_nxt     = r_sel;
        w_acc_nxt     = r_acc;
        w_wb_data_nxt = r_wb_data;
        w_wb_sel_nxt  = r_wb_sel;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_op_nxt  = i_op;
                    w_a_nxt   = i_a;
                    w_b_nxt   = i_b;
                    w_sel_nxt = i_dest_sel;
                    w_cnt_nxt = '0;
                    w_acc_nxt = i_op[1] ? {{WIDTH{1'b0}}, i_a} : '0;
                    if (i_op[1] && (i_b == '0)) begin
                        w_state_nxt   = StWb;
                        w_wb_data_nxt = (i_op == OP_DIVU) ? '1 : i_a;
                        w_wb_sel_nxt  = i_dest_sel;
                    end else begin
                        w_state_nxt = StCalc;
                    end
                end
            end
            StCalc: begin
                if (i_abort) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_is_div) begin
                        w_acc_nxt = w_div_acc;
                    end else begin
                        w_acc_nxt = w_mul_acc;
                        w_b_nxt   = w_b_shr;
                    end
                    if (w_last) begin
                        w_state_nxt   = StWb;
                        w_wb_data_nxt = w_result;
                        w_wb_sel_nxt  = r_sel;
                    end
                end
            end
            StWb: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sel     <= '0;
            r_acc     <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_sel     <= w_sel_nxt;
            r_acc     <= w_acc_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_wb_sel  <= w_wb_sel_nxt;
        end
    end

    assign o_busy    = (r_state != StIdle);
    assign o_done    = (r_state == StWb);
    assign o_wb_wrt  = (r_state == StWb);
    assign o_wb_data = r_wb_data;
    assign o_wb_sel  = r_wb_sel;

endmodule
